joypad_ctrl: RTL and testbench

Controller-side responder for the NES $4016/$4017 serial joypad interface; it models two 4021-style 8-bit parallel-in/serial-out shift registers. It samples raw active-low button pins through synchronisers and debouncers. It latches pad state while the strobe is high and returns one button bit per read pulse on ctrl_data. It sits at top level between the physical pad pins and the APU controller ports ctrl_strobe, ctrl_rd and ctrl_data.

---
 rtl/joypad_ctrl.sv | 166 ++++++++++++++++
 tb/tb_joypad_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/joypad_ctrl.sv
// joypad_ctrl: NES $4016/$4017 responder modelling two 4021-style serial joypad registers.
// Defining JOYPAD_TURBO_EN adds the turbo_n buttons and a free-running turbo phase.
module joypad_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned TURBO_DIV       = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pad0_n,
    input  logic [7:0] pad1_n,
`ifdef JOYPAD_TURBO_EN
    input  logic [3:0] turbo_n,
`endif
    input  logic [2:0] ctrl_strobe,
    input  logic [1:0] ctrl_rd,
    output logic [1:0] ctrl_data
);

`ifdef JOYPAD_TURBO_EN
    localparam int unsigned NB = 20;
`else
    localparam int unsigned NB = 16;
`endif
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [NB-1:0] raw_n;
    logic [NB-1:0] sync1_q;
    logic [NB-1:0] sync2_q;
    logic [NB-1:0] pressed;
    logic [NB-1:0] stable;
    logic [7:0]    load0;
    logic [7:0]    load1;
    logic [7:0]    sr0_q, sr0_d;
    logic [7:0]    sr1_q, sr1_d;
    logic [1:0]    rd_q;
    logic [1:0]    rd_rise;
    logic          unused_strobe_c;

`ifdef JOYPAD_TURBO_EN
    assign raw_n = {turbo_n, pad1_n, pad0_n};
`else
    assign raw_n = {pad1_n, pad0_n};
`endif

    // Two-flop synchroniser; released (1) out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= raw_n;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = ~sync2_q;

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign stable = pressed;
        end else begin : g_debounce
            logic [NB-1:0] stable_q, stable_d;
            logic [CW-1:0] cnt_q [NB];
            logic [CW-1:0] cnt_d [NB];

            // Per-bit counter of consecutive cycles the synced bit disagrees with stable.
            always_comb begin
                stable_d = stable_q;
                for (int i = 0; i < int'(NB); i++) begin
                    cnt_d[i] = '0;
                    if (pressed[i] != stable_q[i]) begin
                        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                            stable_d[i] = pressed[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stable_q <= '0;
                    for (int i = 0; i < int'(NB); i++) begin
                        cnt_q[i] <= '0;
                    end
                end else begin
                    stable_q <= stable_d;
                    for (int i = 0; i < int'(NB); i++) begin
                        cnt_q[i] <= cnt_d[i];
                    end
                end
            end

            assign stable = stable_q;
        end
    endgenerate

`ifdef JOYPAD_TURBO_EN
    localparam int unsigned TW = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;

    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        tcnt_d  = tcnt_q + TW'(1);
        phase_d = phase_q;
        if (tcnt_q == TW'(TURBO_DIV - 1)) begin
            tcnt_d  = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            tcnt_q  <= tcnt_d;
            phase_q <= phase_d;
        end
    end

    // Turbo buttons OR the running phase into A/B.
    assign load0 = stable[7:0]  | {6'b0, stable[17:16] & {2{phase_q}}};
    assign load1 = stable[15:8] | {6'b0, stable[19:18] & {2{phase_q}}};
`else
    assign load0 = stable[7:0];
    assign load1 = stable[15:8];
`endif

    assign rd_rise         = ctrl_rd & ~rd_q;
    assign unused_strobe_c = ^ctrl_strobe[2:1];

    // Strobe loads both pads every cycle; otherwise each rd rising edge shifts a 1 in.
    always_comb begin
        sr0_d = sr0_q;
        sr1_d = sr1_q;
        if (ctrl_strobe[0]) begin
            sr0_d = load0;
            sr1_d = load1;
        end else begin
            if (rd_rise[0]) begin
                sr0_d = {1'b1, sr0_q[7:1]};
            end
            if (rd_rise[1]) begin
                sr1_d = {1'b1, sr1_q[7:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr0_q <= 8'h00;
            sr1_q <= 8'h00;
            rd_q  <= 2'b00;
        end else begin
            sr0_q <= sr0_d;
            sr1_q <= sr1_d;
            rd_q  <= ctrl_rd;
        end
    end

    assign ctrl_data = {sr1_q[0], sr0_q[0]};

endmodule

// File: tb/tb_joypad_ctrl.sv
// tb_joypad_ctrl: randomized and directed bench for joypad_ctrl against a latched-byte/read-index model.
module tb_joypad_ctrl;

    localparam int unsigned DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pad0_n = 8'hFF;
    logic [7:0] pad1_n = 8'hFF;
    logic [2:0] ctrl_strobe = 3'b000;
    logic [1:0] ctrl_rd = 2'b00;
    logic [1:0] ctrl_data;
`ifdef JOYPAD_TURBO_EN
    logic [3:0] turbo_n = 4'hF;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    joypad_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .TURBO_DIV(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pad0_n(pad0_n),
        .pad1_n(pad1_n),
`ifdef JOYPAD_TURBO_EN
        .turbo_n(turbo_n),
`endif
        .ctrl_strobe(ctrl_strobe),
        .ctrl_rd(ctrl_rd),
        .ctrl_data(ctrl_data)
    );

    // Model: pins delayed two edges, run-length debounce, latched byte plus read index per pad.
    logic [15:0] m_pipe1   = '0;
    logic [15:0] m_pipe2   = '0;
    logic [15:0] m_stable  = '0;
    logic [15:0] m_prevsyn = '0;
    logic [1:0]  m_prev_rd = '0;
    int          m_run [16];
    logic [7:0]  m_byte [2];
    int          m_idx [2];

    function automatic logic m_head(input int n);
        logic [7:0] b;
        int         k;
        b = m_byte[n];
        k = m_idx[n];
        if (k >= 8) return 1'b1;
        return b[k[2:0]];
    endfunction

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_pipe1   = '0;
            m_pipe2   = '0;
            m_stable  = '0;
            m_prevsyn = '0;
            m_prev_rd = '0;
            for (int i = 0; i < 16; i++) m_run[i] = 0;
            for (int n = 0; n < 2; n++) begin
                m_byte[n] = '0;
                m_idx[n]  = 0;
            end
        end else begin
            if (ctrl_strobe[0]) begin
                m_byte[0] = m_stable[7:0];
                m_byte[1] = m_stable[15:8];
                m_idx[0]  = 0;
                m_idx[1]  = 0;
            end else begin
                for (int n = 0; n < 2; n++)
                    if (ctrl_rd[n] && !m_prev_rd[n] && m_idx[n] < 8) m_idx[n] = m_idx[n] + 1;
            end
            m_prev_rd = ctrl_rd;
            for (int i = 0; i < 16; i++) begin
                if (m_pipe2[i] == m_prevsyn[i]) begin
                    if (m_run[i] < 1000) m_run[i] = m_run[i] + 1;
                end else begin
                    m_run[i] = 1;
                end
                if (m_pipe2[i] != m_stable[i] && m_run[i] >= int'(DB)) m_stable[i] = m_pipe2[i];
            end
            m_prevsyn = m_pipe2;
            m_pipe2   = m_pipe1;
            m_pipe1   = ~{pad1_n, pad0_n};
        end
    end

    initial forever begin
        @(negedge clk);
        chk("cycle_cmp", ctrl_data, {m_head(1), m_head(0)});
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic rd_pulse(input int n, input int len);
        ctrl_rd[n] = 1'b1;
        tick(len);
        ctrl_rd[n] = 1'b0;
        tick(1);
    endtask

    task automatic strobe_pulse();
        ctrl_strobe[0] = 1'b1;
        tick(2);
        ctrl_strobe[0] = 1'b0;
        tick(1);
    endtask

    logic [9:0] exp_seq;

    initial begin
        exp_seq = 10'b11_1001_0101;
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("reset_state", ctrl_data, 2'b00);

        // Read order: pins 0x6A -> pressed 0x95, then two trailing 1s.
        pad0_n = 8'h6A;
        tick(DB + 4);
        strobe_pulse();
        for (int k = 0; k < 10; k++) begin
            chk("read_order", 2'(ctrl_data[0]), 2'(exp_seq[k]));
            rd_pulse(0, 1);
        end

        // Independent pads.
        pad1_n = 8'hFE;
        tick(DB + 4);
        strobe_pulse();
        chk("indep_rd0_a", 2'(ctrl_data[0]), 2'b01);
        rd_pulse(0, 1);
        chk("indep_rd0_b", 2'(ctrl_data[0]), 2'b00);
        rd_pulse(0, 1);
        chk("indep_rd1_a", 2'(ctrl_data[1]), 2'b01);
        rd_pulse(1, 1);
        chk("indep_rd0_sel", 2'(ctrl_data[0]), 2'b01);
        rd_pulse(0, 1);
        chk("indep_pad1_next", 2'(ctrl_data[1]), 2'b00);
        chk("indep_pad0_next", 2'(ctrl_data[0]), 2'b00);

        // Strobe held high ignores reads; a long rd shifts once.
        ctrl_strobe = 3'b111;
        tick(1);
        for (int k = 0; k < 5; k++) begin
            chk("strobe_hold", 2'(ctrl_data[0]), 2'b01);
            rd_pulse(0, 1);
        end
        ctrl_strobe = 3'b110;
        tick(1);
        chk("strobe_low_a", 2'(ctrl_data[0]), 2'b01);
        rd_pulse(0, 3);
        chk("long_rd_once", 2'(ctrl_data[0]), 2'b00);
        rd_pulse(0, 1);
        chk("long_rd_next", 2'(ctrl_data[0]), 2'b01);
        ctrl_strobe = 3'b000;

        // Debounce on pad1 A observed through a held strobe.
        pad1_n = 8'hFF;
        tick(DB + 4);
        ctrl_strobe[0] = 1'b1;
        tick(2);
        chk("db_idle", 2'(ctrl_data[1]), 2'b00);
        pad1_n[0] = 1'b0;
        tick(DB - 1);
        pad1_n[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            chk("db_glitch", 2'(ctrl_data[1]), 2'b00);
        end
        pad1_n[0] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            chk("db_wait", 2'(ctrl_data[1]), 2'b00);
        end
        tick(1);
        chk("db_press", 2'(ctrl_data[1]), 2'b01);
        ctrl_strobe[0] = 1'b0;
        tick(1);

        // Reset mid-read.
        strobe_pulse();
        rd_pulse(0, 1);
        rd_pulse(0, 1);
        chk("pre_reset", 2'(ctrl_data[0]), 2'b01);
        rst = 1'b1;
        #1;
        chk("reset_async", ctrl_data, 2'b00);
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("reset_release", ctrl_data, 2'b00);

        // Randomized traffic checked every cycle against the model.
        for (int it = 0; it < 600; it++) begin
            case ($urandom_range(0, 6))
                0: begin pad0_n = 8'($urandom); tick(int'($urandom_range(1, 8))); end
                1: begin pad1_n = 8'($urandom); tick(int'($urandom_range(1, 8))); end
                2: begin
                    int b;
                    int len;
                    b   = int'($urandom_range(0, 7));
                    len = int'($urandom_range(1, 6));
                    if ($urandom_range(0, 1) == 1) begin
                        pad1_n[b] = ~pad1_n[b]; tick(len); pad1_n[b] = ~pad1_n[b];
                    end else begin
                        pad0_n[b] = ~pad0_n[b]; tick(len); pad0_n[b] = ~pad0_n[b];
                    end
                    tick(1);
                end
                3: begin
                    ctrl_strobe = {2'($urandom), 1'b1};
                    tick(int'($urandom_range(1, 3)));
                    ctrl_strobe = {2'($urandom), 1'b0};
                    tick(1);
                end
                4: begin
                    ctrl_rd = 2'($urandom_range(1, 3));
                    tick(int'($urandom_range(1, 3)));
                    ctrl_rd = 2'b00;
                    tick(int'($urandom_range(1, 2)));
                end
                5: begin
                    ctrl_rd[$urandom_range(0, 1)] = 1'b1;
                    tick(1);
                    ctrl_rd = 2'($urandom);
                    tick(1);
                    ctrl_rd = 2'b00;
                    tick(1);
                end
                default: tick(int'($urandom_range(1, 4)));
            endcase
        end
        ctrl_rd = 2'b00;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
